// File: rtl/clock_period_monitor.sv
// Measures period and high time (in clk cycles) of a clk-synchronous waveform, with lock and timeout flags.
// Optional macro CLKMON_SYNC_EN inserts a 2-flop input synchronizer, which delays all responses by 2 cycles.
module clock_period_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  typedef enum logic {IDLE, MEAS} state_e;

  state_e           state_q, state_d;
  logic             sig_s, sig_d_q, rise;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
  logic [3:0]       match_q, match_d;

`ifdef CLKMON_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], sig_in};
  end
  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif

  // sig_d resets to 0, so a high input right after reset counts as a rise.
  assign rise = sig_s & ~sig_d_q;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    match_d   = match_q;
    if (state_q == IDLE) begin
      if (rise) begin
        per_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        hi_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        state_d   = MEAS;
      end
    end else if (rise) begin
      period_d  = per_cnt_q;
      high_d    = hi_cnt_q;
      valid_d   = 1'b1;
      timeout_d = 1'b0;
      per_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      hi_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
      // match_q==0 marks the first measurement since reset or timeout.
      if (match_q == 4'd0 || per_cnt_q != period_q || hi_cnt_q != high_q) match_d = 4'd1;
      else if (match_q < LOCK_TGT)                                       match_d = match_q + 4'd1;
      locked_d = (match_d == LOCK_TGT);
    end else if (per_cnt_q == CNT_MAX) begin
      state_d   = IDLE;
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      match_d   = 4'd0;
    end else begin
      per_cnt_d = per_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      hi_cnt_d  = hi_cnt_q + {{(CNT_W-1){1'b0}}, sig_s};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sig_d_q   <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      match_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      sig_d_q   <= sig_s;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      match_q   <= match_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_period_monitor.sv
// Bench for clock_period_monitor (CNT_W=4, LOCK_CNT=4): directed scenarios plus random waveforms,
// all checked cycle by cycle against a sample-history reference model.
module tb_clock_period_monitor;

  localparam int CNT_W    = 4;
  localparam int LOCK_CNT = 4;
  localparam int MAXP     = (1 << CNT_W) - 1;

  logic clk = 1'b0, reset = 1'b1, sig_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic meas_valid, locked, timeout;
  logic [2*CNT_W+2:0] obs;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  clock_period_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .locked(locked), .timeout(timeout)
  );

  assign obs = {period, high_time, meas_valid, locked, timeout};

  // Model: samples since the last rise, and the list of measurements since going idle.
  bit m_prev, m_active;
  bit m_samp[$];
  int m_per[$], m_hi[$];
  int e_period, e_high;
  bit e_valid, e_locked, e_timeout;

  task automatic model_step(input bit rst, input bit s);
    bit rise, lk;
    int per, hi, n;
    e_valid = 1'b0;
    if (rst) begin
      m_prev = 0; m_active = 0;
      m_samp.delete(); m_per.delete(); m_hi.delete();
      e_period = 0; e_high = 0; e_locked = 0; e_timeout = 0;
      return;
    end
    rise = s && !m_prev;
    m_prev = s;
    if (!m_active) begin
      if (rise) begin
        m_active = 1;
        m_samp.delete();
        m_samp.push_back(1'b1);
      end
    end else if (rise) begin
      per = m_samp.size();
      hi = 0;
      foreach (m_samp[i]) hi += int'(m_samp[i]);
      e_period = per; e_high = hi; e_valid = 1; e_timeout = 0;
      m_per.push_back(per); m_hi.push_back(hi);
      n = m_per.size();
      lk = (n >= LOCK_CNT);
      for (int i = 1; i < LOCK_CNT && lk; i++)
        if (m_per[n-1-i] != per || m_hi[n-1-i] != hi) lk = 0;
      e_locked = lk;
      m_samp.delete();
      m_samp.push_back(1'b1);
    end else if (m_samp.size() == MAXP) begin
      m_active = 0; e_timeout = 1; e_locked = 0;
      m_samp.delete(); m_per.delete(); m_hi.delete();
    end else begin
      m_samp.push_back(s);
    end
  endtask

  function automatic logic [2*CNT_W+2:0] exp_vec();
    return {e_period[CNT_W-1:0], e_high[CNT_W-1:0], e_valid, e_locked, e_timeout};
  endfunction

  task automatic step(input bit rst, input bit s);
    @(negedge clk);
    reset = rst;
    sig_in = s;
    model_step(rst, s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      tests++;
      if (obs !== '0) begin fails++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, obs); end
    end
  endtask

  task automatic test_div2();
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, (i % 2) == 0);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL div2_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
      if (meas_valid) begin
        pulses++;
        if (pulses == 1) begin
          tests++;
          if (period !== 4'd2 || high_time !== 4'd1 || i != 2) begin
            fails++; $display("FAIL div2_first cyc=%0d got per=%0d hi=%0d exp per=2 hi=1 cyc=2", i, period, high_time);
          end
        end
        if (pulses == 3 || pulses == 4) begin
          tests++;
          if (locked !== (pulses == 4)) begin
            fails++; $display("FAIL div2_lock pulse=%0d got=%b exp=%b", pulses, locked, pulses == 4);
          end
        end
      end
    end
  endtask

  task automatic test_div6();
    bit pat [6] = '{0, 1, 1, 1, 0, 0};
    int pulses = 0;
    step(1, 0);
    for (int i = 0; i < 36; i++) begin
      step(0, pat[i % 6]);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL div6_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
      if (meas_valid) begin
        pulses++;
        tests++;
        if (period !== 4'd6 || high_time !== 4'd3 || timeout !== 1'b0 || locked !== (pulses >= 4)) begin
          fails++;
          $display("FAIL div6_pulse n=%0d got per=%0d hi=%0d to=%b lk=%b exp per=6 hi=3 to=0 lk=%b",
                   pulses, period, high_time, timeout, locked, pulses >= 4);
        end
      end
    end
  endtask

  task automatic test_ratio_change();
    bit p4 [4] = '{1, 1, 0, 0};
    bit p6 [6] = '{1, 1, 1, 0, 0, 0};
    int c6 = 0;
    step(1, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, p4[i % 4]);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL ratio4_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
    tests++;
    if (locked !== 1'b1 || period !== 4'd4 || high_time !== 4'd2) begin
      fails++; $display("FAIL ratio4_locked got lk=%b per=%0d hi=%0d exp lk=1 per=4 hi=2", locked, period, high_time);
    end
    for (int i = 0; i < 36; i++) begin
      step(0, p6[i % 6]);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL ratio6_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
      if (meas_valid && period == 4'd6) begin
        c6++;
        if (c6 == 1 || c6 == 4) begin
          tests++;
          if (locked !== (c6 == 4)) begin fails++; $display("FAIL ratio6_lock n=%0d got=%b exp=%b", c6, locked, c6 == 4); end
        end
      end
    end
  endtask

  task automatic test_timeout();
    step(1, 0);
    for (int i = 0; i < 30; i++) begin
      step(0, i == 0 || i == 5 || i == 24 || i == 27);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL timeout_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
      if (i == 5) begin
        tests++;
        if (meas_valid !== 1'b1 || period !== 4'd5) begin fails++; $display("FAIL timeout_meas5 got v=%b per=%0d exp v=1 per=5", meas_valid, period); end
      end
      if (i == 19) begin
        tests++;
        if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_early got=%b exp=0", timeout); end
      end
      if (i == 20) begin
        tests++;
        if (timeout !== 1'b1 || locked !== 1'b0 || period !== 4'd5) begin
          fails++; $display("FAIL timeout_fire got to=%b lk=%b per=%0d exp to=1 lk=0 per=5", timeout, locked, period);
        end
      end
      if (i == 27) begin
        tests++;
        if (meas_valid !== 1'b1 || period !== 4'd3 || timeout !== 1'b0) begin
          fails++; $display("FAIL timeout_recover got v=%b per=%0d to=%b exp v=1 per=3 to=0", meas_valid, period, timeout);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int late_pulses = 0;
    step(1, 0);
    for (int i = 0; i < 36; i++) begin
      step(0, i == 0 || i == 15 || i == 31);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL bound_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
      if (i > 15 && meas_valid) late_pulses++;
      if (i == 15) begin
        tests++;
        if (meas_valid !== 1'b1 || period !== 4'd15 || timeout !== 1'b0) begin
          fails++; $display("FAIL bound_15 got v=%b per=%0d to=%b exp v=1 per=15 to=0", meas_valid, period, timeout);
        end
      end
      if (i == 30) begin
        tests++;
        if (timeout !== 1'b1) begin fails++; $display("FAIL bound_16_timeout got=%b exp=1", timeout); end
      end
    end
    tests++;
    if (late_pulses != 0) begin fails++; $display("FAIL bound_16_nomeas got=%0d pulses exp=0", late_pulses); end
  endtask

  task automatic test_reset_mid();
    bit p4 [4] = '{1, 1, 0, 0};
    int pulses_after = 0;
    step(1, 0);
    for (int i = 0; i < 22; i++) begin
      step(i == 10, p4[i % 4]);
      tests++;
      if (obs !== exp_vec()) begin fails++; $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", i, obs, exp_vec()); end
      if (i == 10) begin
        tests++;
        if (obs !== '0) begin fails++; $display("FAIL rstmid_clear got=%h exp=0", obs); end
      end
      if (i > 10 && meas_valid) begin
        pulses_after++;
        if (pulses_after == 1) begin
          tests++;
          if (i != 16 || period !== 4'd4) begin fails++; $display("FAIL rstmid_first cyc=%0d per=%0d exp cyc=16 per=4", i, period); end
        end
      end
    end
  endtask

  task automatic test_random();
    int p, h, reps, cyc;
    cyc = 0;
    step(1, 0);
    while (cyc < 3000) begin
      p = $urandom_range(1, 18);
      h = $urandom_range(0, p);
      reps = $urandom_range(1, 8);
      for (int r = 0; r < reps; r++) begin
        for (int k = 0; k < p; k++) begin
          step($urandom_range(0, 199) == 0, k < h);
          tests++;
          if (obs !== exp_vec()) begin
            fails++; $display("FAIL random_model cyc=%0d p=%0d h=%0d got=%h exp=%h", cyc, p, h, obs, exp_vec());
          end
          cyc++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div6();
    test_ratio_change();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
